// File: rtl/cmd_resp_uart.sv
// Two-byte command receiver plus one-byte response transmitter sharing one UART pair.
// cmd_rdy rises one clock after the second stop sample; TX falls one clock after an accepted trmt.
module cmd_resp_uart #(
    parameter int BAUD_CNT = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        trmt,
    input  logic [7:0]  resp,
    output logic        tx_done
);

    localparam int BW = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_CNT / 2 - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    localparam logic [0:0] RX_IDLE = 1'b0;
    localparam logic [0:0] RX_RECV = 1'b1;
    localparam logic [0:0] AS_HIGH = 1'b0;
    localparam logic [0:0] AS_LOW  = 1'b1;
    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_XMIT = 1'b1;

    logic          rx_ff1, rx_ff2, rx_prev;
    logic [0:0]    rx_state;
    logic [BW-1:0] rx_baud;
    logic [3:0]    rx_bits;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_byte;
    logic          rx_vld;

    logic [0:0]    as_state;

    logic [0:0]    tx_state;
    logic [BW-1:0] tx_baud;
    logic [3:0]    tx_bits;
    logic [9:0]    tx_shift;

    // RX is asynchronous; rx_prev only feeds the falling-edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1  <= 1'b1;
            rx_ff2  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_ff1  <= RX;
            rx_ff2  <= rx_ff1;
            rx_prev <= rx_ff2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_baud  <= '0;
            rx_bits  <= 4'd0;
            rx_shift <= 8'h00;
            rx_byte  <= 8'h00;
            rx_vld   <= 1'b0;
        end else begin
            rx_vld <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_ff2) begin
                        rx_state <= RX_RECV;
                        rx_baud  <= HALF_LAST;
                        rx_bits  <= 4'd0;
                    end
                end
                default: begin
                    if (rx_baud == '0) begin
                        rx_baud <= BAUD_LAST;
                        if (rx_bits == 4'd9) begin
                            // Stop sample: byte accepted whatever the stop level.
                            rx_state <= RX_IDLE;
                            rx_baud  <= '0;
                            rx_bits  <= 4'd0;
                            rx_byte  <= rx_shift;
                            rx_vld   <= 1'b1;
                        end else begin
                            if (rx_bits != 4'd0)
                                rx_shift <= {rx_ff2, rx_shift[7:1]};
                            rx_bits <= rx_bits + 4'd1;
                        end
                    end else begin
                        rx_baud <= rx_baud - BAUD_ONE;
                    end
                end
            endcase
        end
    end

    // Completion of the low byte wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            as_state <= AS_HIGH;
            cmd      <= 16'h0000;
            cmd_rdy  <= 1'b0;
        end else begin
            if (rx_vld) begin
                if (as_state == AS_HIGH) begin
                    cmd[15:8] <= rx_byte;
                    as_state  <= AS_LOW;
                end else begin
                    cmd[7:0]  <= rx_byte;
                    as_state  <= AS_HIGH;
                end
            end
            if (rx_vld && as_state == AS_LOW)
                cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || rx_vld)
                cmd_rdy <= 1'b0;
        end
    end

    // Shifting in ones leaves the register all-ones after the stop bit, so TX idles high.
    assign TX = tx_shift[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_baud  <= '0;
            tx_bits  <= 4'd0;
            tx_shift <= 10'h3FF;
            tx_done  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (trmt) begin
                        tx_shift <= {1'b1, resp, 1'b0};
                        tx_done  <= 1'b0;
                        tx_state <= TX_XMIT;
                        tx_baud  <= '0;
                        tx_bits  <= 4'd0;
                    end
                end
                default: begin
                    if (tx_baud == BAUD_LAST) begin
                        tx_baud  <= '0;
                        tx_shift <= {1'b1, tx_shift[9:1]};
                        if (tx_bits == 4'd9) begin
                            tx_state <= TX_IDLE;
                            tx_bits  <= 4'd0;
                            tx_done  <= 1'b1;
                        end else begin
                            tx_bits <= tx_bits + 4'd1;
                        end
                    end else begin
                        tx_baud <= tx_baud + BAUD_ONE;
                    end
                end
            endcase
        end
    end

endmodule
